// File: rtl/dspl_scan_driver.sv
// dspl_scan_driver
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// One digit is lit per slot of SCAN_DIV cycles. The first GUARD_CYCLES of
// each slot keep all anodes off to suppress ghosting.
// Each digit word is {enable, hex[3:0], dp_n}. d1 is the rightmost digit (an[0]).
// Optional feature: define DSPL_SCAN_FRAME_LATCH_EN to snapshot all eight
// words once per frame so that a frame never mixes old and new values.
// All outputs are registered.

module dspl_scan_driver #(
   parameter int unsigned SCAN_DIV     = 100000,
   parameter int unsigned GUARD_CYCLES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] d1,
   input  logic [5:0] d2,
   input  logic [5:0] d3,
   input  logic [5:0] d4,
   input  logic [5:0] d5,
   input  logic [5:0] d6,
   input  logic [5:0] d7,
   input  logic [5:0] d8,
   output logic [7:0] an,
   output logic [7:0] dec_cat
);

   localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] slot_cnt_q, slot_cnt_d;
   logic [2:0]    scan_idx_q, scan_idx_d;
   logic [7:0]    an_q, an_d;
   logic [7:0]    cat_q, cat_d;
   logic          slot_wrap;
   logic          in_guard;
   logic [5:0]    d_live [8];
   logic [5:0]    w;
   logic [6:0]    seg;

   assign d_live[0] = d1;
   assign d_live[1] = d2;
   assign d_live[2] = d3;
   assign d_live[3] = d4;
   assign d_live[4] = d5;
   assign d_live[5] = d6;
   assign d_live[6] = d7;
   assign d_live[7] = d8;

   assign slot_wrap = (slot_cnt_q == CW'(SCAN_DIV - 1));

   // A zero-length guard would make the compare constant, so it is elided.
   generate
      if (GUARD_CYCLES == 0) begin : g_no_guard
         assign in_guard = 1'b0;
      end else begin : g_guard
         assign in_guard = (32'(slot_cnt_q) < 32'(GUARD_CYCLES));
      end
   endgenerate

`ifdef DSPL_SCAN_FRAME_LATCH_EN
   logic [5:0] snap_q [8];
   logic       snap_load;

   // Snapshot is taken on the last cycle of slot 7, so the next frame sees a coherent set.
   assign snap_load = slot_wrap && (scan_idx_q == 3'd7);

   // Frame snapshot registers; reset to blank words.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) snap_q[i] <= '0;
      end else if (snap_load) begin
         for (int i = 0; i < 8; i++) snap_q[i] <= d_live[i];
      end
   end

   assign w = snap_q[scan_idx_q];
`else
   assign w = d_live[scan_idx_q];
`endif

   // Slot counter wraps every SCAN_DIV cycles and advances the digit index.
   always_comb begin
      slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
      scan_idx_d = slot_wrap ? scan_idx_q + 3'd1 : scan_idx_q;
   end

   // Active-low hex font, segment order a..g.
   always_comb begin
      case (w[4:1])
         4'h0:    seg = 7'b0000001;
         4'h1:    seg = 7'b1001111;
         4'h2:    seg = 7'b0010010;
         4'h3:    seg = 7'b0000110;
         4'h4:    seg = 7'b1001100;
         4'h5:    seg = 7'b0100100;
         4'h6:    seg = 7'b0100000;
         4'h7:    seg = 7'b0001111;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0000100;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b1100000;
         4'hC:    seg = 7'b0110001;
         4'hD:    seg = 7'b1000010;
         4'hE:    seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
   end

   // Anode and cathode next values; blank during guard or for a disabled word.
   always_comb begin
      an_d  = 8'hFF;
      cat_d = 8'hFF;
      if (!in_guard && w[5]) begin
         an_d  = ~(8'h01 << scan_idx_q);
         cat_d = {seg, w[0]};
      end
   end

   // Scan state and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         slot_cnt_q <= '0;
         scan_idx_q <= '0;
         an_q       <= 8'hFF;
         cat_q      <= 8'hFF;
      end else begin
         slot_cnt_q <= slot_cnt_d;
         scan_idx_q <= scan_idx_d;
         an_q       <= an_d;
         cat_q      <= cat_d;
      end
   end

   assign an      = an_q;
   assign dec_cat = cat_q;

endmodule
